i2s_dac_serializer: RTL
=======================

I2S_DAC_SERIALIZER -- requirements
Module: i2s_dac_serializer

Interface
REQ-001 Parameter SLOT_BITS, default 32: bits per channel slot. Frame is 2*SLOT_BITS bclk.
REQ-002 Parameter BCLK_DIV, default 8: clk cycles per bclk. 49.152 MHz / 8 / 64 = 96 kHz frame.
REQ-003 clk  input  1  sole clock, 49.152 MHz mclk.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  enable. Low means idle and flush.
REQ-006 din_valid  input  1  one-cycle strobe qualifying l_data_in/r_data_in (interpolator dout_valid).
REQ-007 l_data_in, r_data_in  input  34  signed two's-complement interpolated samples.
REQ-008 gain_shift  input  4  arithmetic right shift, 0..10; values 11..15 treated as 10.
REQ-009 bclk, lrclk, sdata  output  1 each  I2S DAC bus; lrclk low means left.
REQ-010 overrun, underrun  output  1 each  sticky error flags.
REQ-011 test_data  output  16  {fifo_count[1:0], underrun, overrun, lrclk, bclk, 10'b0}.

Function
REQ-012 9-bit frame counter fcnt runs 0..511 while run=1, wraps 511->0, and is held at 0 while run=0.
REQ-013 bclk, lrclk and sdata are registered; each equals its fcnt-derived value delayed one clk. bclk = fcnt[2]; lrclk = fcnt[8].
REQ-014 Slot bit index b = fcnt[7:3]. sdata = sample[24-b] for b in 1..24, else 0. This gives MSB one bclk after the lrclk edge, 24 data bits, then zero padding.
REQ-015 sdata changes only where bclk goes low (fcnt[2:0]==0), so it is stable at every bclk rising edge.
REQ-016 Scaling per channel, computed on FIFO write: x = din >>> gain_shift (sign-extending), then saturate to 24-bit signed range [-8388608, 8388607].
REQ-017 Buffer: 2-entry FIFO of 48-bit {left24, right24} pairs.
REQ-018 Push on din_valid && run.
REQ-019 Pop when fcnt==511. The popped pair drives the frame that starts at fcnt==0.
REQ-020 Push while full: the new pair is dropped and overrun is set.
REQ-021 Pop while empty: the frame transmits all-zero samples and underrun is set.
REQ-022 Push and pop in the same cycle: pop completes first, so a full FIFO still accepts the push; on an empty FIFO the push is stored and the pop underruns.
REQ-023 Latency: a pair pushed at least one cycle before fcnt==511 (with the FIFO empty) has its left MSB on sdata at fcnt==9 of the next frame (registered, b=1).
REQ-024 run going low: on the next clk, fcnt, bclk, lrclk and sdata go to 0, the FIFO empties, and the holding register clears.
REQ-025 overrun and underrun hold their value until reset_n is asserted or run is low; they clear on either.
REQ-026 run rising: first frame starts at fcnt==0 with zero samples; underrun is not flagged for that first frame.

Reset
REQ-027 reset_n low asynchronously sets:
- fcnt, FIFO pointers and count to 0;
- holding registers to 0;
- bclk, lrclk, sdata to 0;
- overrun, underrun to 0.
REQ-028 After reset_n release, behaviour is identical to run rising.

Structure
REQ-029 Shared audio package holds SLOT_BITS, BCLK_DIV, FRAME_LEN=512, the sample width 24 and the interpolator output width 34.
REQ-030 Sub-module sat_shift24 (combinational shift plus saturate) is instantiated once per channel.
REQ-031 FIFO, frame counter and shifter live in this module; no vendor IP.

Verification
REQ-032 Reset/idle: reset_n=0, then run=1. Required: bclk period 8 clk, lrclk period 512 clk, 32 bclk low and 32 high, underrun=0 during the first frame.
REQ-033 Single sample: push L=34'h0_0001_2345_6, R=-1, gain_shift=4. Required: left slot carries 24'h012345, right slot carries 24'hFFFFFF, MSBs at b=1 of the next frame.
REQ-034 Saturation: L=34'h1_0000_0000, R=34'h2_0000_0000, gain_shift=0. Required: 24'h7FFFFF and 24'h800000.
REQ-035 Overrun: three pushes within one frame. Required: third pair dropped, overrun=1, first two pairs transmitted in order.
REQ-036 Underrun and push-pop collision:
- no push for one frame, then run continuing: required zero samples, underrun=1;
- push exactly at fcnt==511 with the FIFO full: required no overrun.
REQ-037 Mid-frame abort: run=0 at fcnt==300. Required: outputs 0 next clk, FIFO empty, flags cleared; run=1 restarts at fcnt=0.

Source files
------------

// File: rtl/i2s_dac_serializer_pkg.sv
// Shared audio constants and types for the interpolator-to-DAC output path.
package i2s_dac_serializer_pkg;

  localparam int unsigned DEF_SLOT_BITS = 32;
  localparam int unsigned DEF_BCLK_DIV  = 8;
  localparam int unsigned FRAME_LEN     = 512;
  localparam int unsigned SAMPLE_W      = 24;
  localparam int unsigned DIN_W         = 34;
  localparam int unsigned MAX_SHIFT     = 10;
  localparam int unsigned FIFO_DEPTH    = 2;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [DIN_W-1:0]    din_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } pair_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  function automatic logic [3:0] clamp_shift(input logic [3:0] sh);
    return (sh > 4'(MAX_SHIFT)) ? 4'(MAX_SHIFT) : sh;
  endfunction

endpackage

// File: rtl/i2s_dac_serializer_sat_shift24.sv
// Per-channel gain: arithmetic right shift (clamped to 10) then saturation to 24-bit signed.
module sat_shift24
  import i2s_dac_serializer_pkg::*;
(
  input  din_t       din_i,
  input  logic [3:0] shift_i,
  output sample_t    dout_o
);

  localparam int unsigned HEAD_W = DIN_W - SAMPLE_W + 1;

  din_t              shifted;
  logic [HEAD_W-1:0] head;

  always_comb begin
    shifted = din_i >>> clamp_shift(shift_i);
    // In range only when every bit above the 24-bit sign position repeats the sign.
    head = shifted[DIN_W-1:SAMPLE_W-1];
    if ((&head) || !(|head)) begin
      dout_o = shifted[SAMPLE_W-1:0];
    end else if (shifted[DIN_W-1]) begin
      dout_o = {1'b1, {(SAMPLE_W-1){1'b0}}};
    end else begin
      dout_o = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/i2s_dac_serializer.sv
// I2S DAC serializer: scales stereo pairs into a 2-deep FIFO and shifts one pair per frame.
module i2s_dac_serializer
  import i2s_dac_serializer_pkg::*;
#(
  parameter int unsigned SLOT_BITS = DEF_SLOT_BITS,
  parameter int unsigned BCLK_DIV  = DEF_BCLK_DIV
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             din_valid,
  input  logic [DIN_W-1:0] l_data_in,
  input  logic [DIN_W-1:0] r_data_in,
  input  logic [3:0]       gain_shift,
  output logic             bclk,
  output logic             lrclk,
  output logic             sdata,
  output logic             overrun,
  output logic             underrun,
  output logic [15:0]      test_data
);

  localparam int unsigned DIV_W  = $clog2(BCLK_DIV);
  localparam int unsigned SLOT_W = $clog2(SLOT_BITS);
  localparam int unsigned CNT_W  = 1 + SLOT_W + DIV_W;
  localparam int unsigned IDX_W  = $clog2(SAMPLE_W);

  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic             bclk_q, bclk_d;
  logic             lrclk_q, lrclk_d;
  logic             sdata_q, sdata_d;
  pair_t            hold_q, hold_d;
  pair_t            fifo_q [FIFO_DEPTH];
  pair_t            fifo_d [FIFO_DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             underrun_q, underrun_d;

  sample_t           l_scaled, r_scaled;
  logic              frame_end, push, pop, pop_ok, push_ok;
  logic [SLOT_W-1:0] slot_b;
  chan_e             chan;
  sample_t           cur_sample;
  logic [IDX_W-1:0]  bit_idx;
  logic              in_window;

  sat_shift24 u_sat_l (
    .din_i   (l_data_in),
    .shift_i (gain_shift),
    .dout_o  (l_scaled)
  );

  sat_shift24 u_sat_r (
    .din_i   (r_data_in),
    .shift_i (gain_shift),
    .dout_o  (r_scaled)
  );

  always_comb begin
    frame_end  = &fcnt_q;
    push       = din_valid & run;
    pop        = run & frame_end;
    pop_ok     = pop & (count_q != '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    push_ok    = push & ((count_q != 2'(FIFO_DEPTH)) | pop_ok);

    slot_b     = fcnt_q[CNT_W-2:DIV_W];
    chan       = chan_e'(fcnt_q[CNT_W-1]);
    cur_sample = (chan == CH_RIGHT) ? hold_q.right : hold_q.left;
    bit_idx    = IDX_W'(SAMPLE_W - 32'(slot_b));
    in_window  = (slot_b != '0) && (32'(slot_b) <= SAMPLE_W);

    fcnt_d     = fcnt_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    hold_d     = hold_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;

    if (!run) begin
      fcnt_d     = '0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      count_d    = '0;
      hold_d     = '0;
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end else begin
      fcnt_d = fcnt_q + 1'b1;
      if (pop) begin
        if (pop_ok) begin
          hold_d   = fifo_q[rd_ptr_q];
          rd_ptr_d = ~rd_ptr_q;
        end else begin
          hold_d     = '0;
          underrun_d = 1'b1;
        end
      end
      if (push_ok) begin
        fifo_d[wr_ptr_q] = {l_scaled, r_scaled};
        wr_ptr_d         = ~wr_ptr_q;
      end else if (push) begin
        overrun_d = 1'b1;
      end
      count_d = count_q + 2'(push_ok) - 2'(pop_ok);
    end

    bclk_d  = run & fcnt_q[DIV_W-1];
    lrclk_d = run & fcnt_q[CNT_W-1];
    sdata_d = run & in_window & cur_sample[bit_idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fcnt_q     <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      hold_q     <= '0;
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      fcnt_q     <= fcnt_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      hold_q     <= hold_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  assign bclk      = bclk_q;
  assign lrclk     = lrclk_q;
  assign sdata     = sdata_q;
  assign overrun   = overrun_q;
  assign underrun  = underrun_q;
  assign test_data = {count_q, underrun_q, overrun_q, lrclk_q, bclk_q, 10'b0};

endmodule
